// File: rtl/fetch_unit_pkg.sv
// Shared widths, reset PC and issue-window helper for the instruction fetch front end.
package fetch_unit_pkg;

  localparam int ADDR_W_DEF   = 8;
  localparam int INSN_W_DEF   = 32;
  localparam int RESET_PC_DEF = 0;

  // Room for one more read once words held plus words in flight, net of this cycle's pop, stay below two.
  function automatic logic issue_ok(input logic [1:0] occ, input logic inflight, input logic pop);
    return ({1'b0, occ} + {2'b00, inflight}) < (3'd2 + {2'b00, pop});
  endfunction

endpackage

// File: rtl/fetch_queue.sv
// Two-entry FIFO of {pc, insn}; head is always entry0 so outputs come straight from registers.
module fetch_queue #(
  parameter int W = 40
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  logic [W-1:0] din,
  output logic [1:0]   occ,
  output logic [W-1:0] head
);

  logic [W-1:0] entry0;
  logic [W-1:0] entry1;
  logic         pop_ok;

  assign pop_ok = pop && (occ != 2'd0);
  assign head   = entry0;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      occ    <= 2'd0;
      entry0 <= '0;
      entry1 <= '0;
    end else if (flush) begin
      occ <= 2'd0;
    end else begin
      case ({push, pop_ok})
        2'b10: begin
          if (occ == 2'd0) begin
            entry0 <= din;
            occ    <= 2'd1;
          end else if (occ == 2'd1) begin
            entry1 <= din;
            occ    <= 2'd2;
          end
        end
        2'b01: begin
          entry0 <= entry1;
          occ    <= occ - 2'd1;
        end
        2'b11: begin
          // Occupancy is unchanged; the pushed word lands behind whatever remains.
          if (occ == 2'd1) begin
            entry0 <= din;
          end else begin
            entry0 <= entry1;
            entry1 <= din;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: owns the PC, issues one read per cycle and buffers returned words for decode.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int INSN_W   = INSN_W_DEF,
  parameter int RESET_PC = RESET_PC_DEF
) (
  input  logic              clk,
  input  logic              reset,
  output logic              imem_en,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [INSN_W-1:0] imem_rdata,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              insn_valid,
  input  logic              insn_ready,
  output logic [INSN_W-1:0] insn_data,
  output logic [ADDR_W-1:0] insn_pc
);

  localparam int QW = ADDR_W + INSN_W;
  localparam logic [ADDR_W-1:0] START_PC = ADDR_W'(RESET_PC);

  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] inflight_addr;
  logic              inflight;
  logic [1:0]        occ;
  logic [QW-1:0]     head;
  logic              pop;
  logic              push;
  logic              issue;

  assign insn_valid = (occ != 2'd0);
  assign pop        = insn_valid & insn_ready;
  // A redirect kills the read returning this cycle, so its data is never queued.
  assign push       = inflight & ~redirect_valid;

  always_comb begin
    issue     = 1'b0;
    imem_addr = START_PC;
    if (reset) begin
      issue     = redirect_valid | issue_ok(occ, inflight, pop);
      imem_addr = redirect_valid ? redirect_pc : pc;
    end
  end

  assign imem_en = issue;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc            <= START_PC;
      inflight      <= 1'b0;
      inflight_addr <= START_PC;
    end else begin
      inflight <= issue;
      if (issue) begin
        pc            <= imem_addr + 1'b1;
        inflight_addr <= imem_addr;
      end
    end
  end

  fetch_queue #(
    .W(QW)
  ) u_queue (
    .clk  (clk),
    .reset(reset),
    .push (push),
    .pop  (pop),
    .flush(redirect_valid),
    .din  ({inflight_addr, imem_rdata}),
    .occ  (occ),
    .head (head)
  );

  assign {insn_pc, insn_data} = head;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: expected {pc, insn} pushed to a scoreboard, popped on each decode handshake.
module tb_fetch_unit;

  typedef struct {
    logic [7:0]  pc;
    logic [31:0] data;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_en;
  logic [7:0]  imem_addr;
  logic [31:0] imem_rdata = '0;
  logic        redirect_valid;
  logic [7:0]  redirect_pc;
  logic        insn_valid;
  logic        insn_ready;
  logic [31:0] insn_data;
  logic [7:0]  insn_pc;

  exp_t sb[$];
  int   n_asserts = 0;
  int   n_fail    = 0;

  fetch_unit #(
    .ADDR_W  (8),
    .INSN_W  (32),
    .RESET_PC(0)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .imem_en       (imem_en),
    .imem_addr     (imem_addr),
    .imem_rdata    (imem_rdata),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .insn_valid    (insn_valid),
    .insn_ready    (insn_ready),
    .insn_data     (insn_data),
    .insn_pc       (insn_pc)
  );

  always #5 clk = ~clk;

  // Synchronous instruction memory with mem[i] = i + 0x100.
  always @(posedge clk) begin
    if (imem_en) imem_rdata <= 32'h100 + {24'h0, imem_addr};
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_asserts++;
    assert (observed === expected)
    else begin
      n_fail++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic rv, input logic [7:0] rpc, input logic rdy);
    redirect_valid = rv;
    redirect_pc    = rpc;
    insn_ready     = rdy;
  endtask

  task automatic expectWord(input logic [7:0] a);
    exp_t e;
    e.pc   = a;
    e.data = 32'h100 + {24'h0, a};
    sb.push_back(e);
  endtask

  task automatic monitorHandshake();
    exp_t e;
    if (insn_valid === 1'b1 && insn_ready === 1'b1) begin
      n_asserts++;
      assert (sb.size() != 0)
      else begin
        n_fail++;
        $error("[TB] FAIL sb_unexpected observed pc=%0h data=%0h expected none", insn_pc, insn_data);
      end
      if (sb.size() != 0) begin
        e = sb.pop_front();
        checkOutput("sb_pc", 32'(insn_pc), 32'(e.pc));
        checkOutput("sb_data", insn_data, e.data);
      end
    end
  endtask

  task automatic atNeg();
    @(negedge clk);
    monitorHandshake();
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic cyc(input int n);
    for (int i = 0; i < n; i++) begin
      atNeg();
      nextCycle();
    end
  endtask

  initial begin
    reset = 1'b0;
    applyStimulus(1'b0, 8'h00, 1'b1);
    nextCycle();
    nextCycle();
    checkOutput("rst_valid", 32'(insn_valid), 32'd0);
    checkOutput("rst_en", 32'(imem_en), 32'd0);
    checkOutput("rst_addr", 32'(imem_addr), 32'd0);
    checkOutput("rst_data", insn_data, 32'd0);
    checkOutput("rst_pc", 32'(insn_pc), 32'd0);

    for (int a = 0; a < 6; a++) expectWord(8'(a));
    reset = 1'b1;
    atNeg();
    checkOutput("first_en", 32'(imem_en), 32'd1);
    checkOutput("first_addr", 32'(imem_addr), 32'd0);
    nextCycle();
    atNeg();
    checkOutput("c1_addr", 32'(imem_addr), 32'd1);
    checkOutput("c1_valid", 32'(insn_valid), 32'd0);
    nextCycle();
    atNeg();
    checkOutput("c2_valid", 32'(insn_valid), 32'd1);
    checkOutput("c2_addr", 32'(imem_addr), 32'd2);
    nextCycle();
    cyc(1);

    // Decode stalls for five cycles; head must hold 0x102 and fetch must stop.
    applyStimulus(1'b0, 8'h00, 1'b0);
    atNeg();
    checkOutput("stall_data", insn_data, 32'h102);
    checkOutput("stall_pc", 32'(insn_pc), 32'd2);
    checkOutput("stall_en", 32'(imem_en), 32'd0);
    nextCycle();
    for (int i = 0; i < 4; i++) begin
      atNeg();
      checkOutput("hold_data", insn_data, 32'h102);
      checkOutput("hold_valid", 32'(insn_valid), 32'd1);
      checkOutput("hold_en", 32'(imem_en), 32'd0);
      nextCycle();
    end
    applyStimulus(1'b0, 8'h00, 1'b1);
    cyc(3);
    applyStimulus(1'b0, 8'h00, 1'b0);
    cyc(1);

    // Redirect with the queue full while the head handshake completes.
    applyStimulus(1'b1, 8'h40, 1'b1);
    atNeg();
    checkOutput("redir_addr", 32'(imem_addr), 32'h40);
    checkOutput("redir_en", 32'(imem_en), 32'd1);
    nextCycle();
    expectWord(8'h40);
    expectWord(8'h41);
    expectWord(8'h42);
    applyStimulus(1'b0, 8'h00, 1'b1);
    atNeg();
    checkOutput("redir_gap", 32'(insn_valid), 32'd0);
    nextCycle();
    atNeg();
    checkOutput("redir_valid", 32'(insn_valid), 32'd1);
    checkOutput("redir_pc", 32'(insn_pc), 32'h40);
    nextCycle();
    cyc(1);

    // Back-to-back redirects: only the second target may ever appear.
    applyStimulus(1'b1, 8'h10, 1'b1);
    cyc(1);
    expectWord(8'h20);
    expectWord(8'h21);
    expectWord(8'h22);
    applyStimulus(1'b1, 8'h20, 1'b1);
    atNeg();
    checkOutput("b2b_valid0", 32'(insn_valid), 32'd0);
    checkOutput("b2b_addr", 32'(imem_addr), 32'h20);
    nextCycle();
    applyStimulus(1'b0, 8'h00, 1'b1);
    atNeg();
    checkOutput("b2b_valid1", 32'(insn_valid), 32'd0);
    nextCycle();
    cyc(2);

    // PC wrap from 0xFF to 0x00.
    expectWord(8'hFE);
    expectWord(8'hFF);
    expectWord(8'h00);
    expectWord(8'h01);
    applyStimulus(1'b1, 8'hFE, 1'b1);
    cyc(1);
    applyStimulus(1'b0, 8'h00, 1'b1);
    cyc(5);
    applyStimulus(1'b0, 8'h00, 1'b0);
    cyc(1);

    // Asynchronous reset with the queue full.
    checkOutput("full_valid", 32'(insn_valid), 32'd1);
    checkOutput("full_head", insn_data, 32'h102);
    reset = 1'b0;
    #1;
    checkOutput("arst_valid", 32'(insn_valid), 32'd0);
    checkOutput("arst_en", 32'(imem_en), 32'd0);
    checkOutput("arst_pc", 32'(insn_pc), 32'd0);
    applyStimulus(1'b0, 8'h00, 1'b1);
    for (int i = 0; i < 3; i++) begin
      atNeg();
      checkOutput("inrst_valid", 32'(insn_valid), 32'd0);
      checkOutput("inrst_en", 32'(imem_en), 32'd0);
      nextCycle();
    end
    for (int a = 0; a < 4; a++) expectWord(8'(a));
    reset = 1'b1;
    atNeg();
    checkOutput("restart_addr", 32'(imem_addr), 32'd0);
    checkOutput("restart_en", 32'(imem_en), 32'd1);
    nextCycle();
    atNeg();
    checkOutput("restart_gap", 32'(insn_valid), 32'd0);
    nextCycle();
    cyc(4);
    applyStimulus(1'b0, 8'h00, 1'b0);
    cyc(2);

    checkOutput("sb_drained", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
